// File: rtl/dog_pass_sched.sv
// dog_pass_sched: sequences one job as cfg_npass DoG pipeline passes.
// Each pass is launched with dog_start and waits for dog_done. An optional
// idle gap follows each non-final pass. A per-pass watchdog, an abort path
// and a one-cycle job_done pulse complete the host-side handshake.
module dog_pass_sched #(
  parameter int unsigned NUM_PASS = 8,
  parameter int unsigned GAP      = 2,
  parameter int unsigned TIMEOUT  = 131072,
  parameter int unsigned CNT_W    = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic [3:0] cfg_npass,
  input  logic       abort,
  input  logic       dog_done,
  output logic       dog_start,
  output logic [2:0] pass_idx,
  output logic       busy,
  output logic       job_done,
  output logic       err_tmo
);

  localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [3:0]  MAX_NP   = 4'(NUM_PASS);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       npass;
  logic [3:0]       npass_in;
  logic [CNT_W-1:0] wd_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic accept;    // cfg_start taken in IDLE
  logic advance;   // non-final pass completed
  logic expire;    // watchdog expired without dog_done
  logic kill;      // abort honoured
  logic last_pass;

  assign npass_in  = (cfg_npass > MAX_NP) ? MAX_NP : cfg_npass;
  assign last_pass = ({1'b0, pass_idx} == (npass - 4'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and per-cycle control strobes for the datapath.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    advance  = 1'b0;
    expire   = 1'b0;
    kill     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          accept   = 1'b1;
          state_nx = (npass_in == 4'd0) ? S_FIN : S_LAUNCH;
        end
      end
      S_LAUNCH: state_nx = S_RUN;
      S_RUN: begin
        // dog_done takes priority over a watchdog expiry in the same cycle.
        if (dog_done) begin
          if (last_pass) begin
            state_nx = S_FIN;
          end else begin
            advance  = 1'b1;
            state_nx = (GAP > 0) ? S_GAP : S_LAUNCH;
          end
        end else if (wd_cnt == WD_LAST) begin
          expire   = 1'b1;
          state_nx = S_FIN;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nx = S_LAUNCH;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort overrides whatever the active state decided, including dog_done.
    if (abort && (state != S_IDLE)) begin
      kill     = 1'b1;
      advance  = 1'b0;
      expire   = 1'b0;
      state_nx = S_IDLE;
    end
  end

  // Job configuration, pass index and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      npass    <= '0;
      pass_idx <= '0;
      err_tmo  <= 1'b0;
    end else begin
      if (accept) begin
        npass    <= npass_in;
        pass_idx <= '0;
        err_tmo  <= 1'b0;
      end
      if (kill)    pass_idx <= '0;
      if (advance) pass_idx <= pass_idx + 3'd1;
      if (expire)  err_tmo  <= 1'b1;
    end
  end

  // Per-pass watchdog: cleared while launching, counts during RUN.
  always_ff @(posedge clk) begin
    if (rst)                    wd_cnt <= '0;
    else if (state == S_LAUNCH) wd_cnt <= '0;
    else if (state == S_RUN)    wd_cnt <= wd_cnt + CNT_W'(1);
  end

  // Inter-pass gap counter: loaded as the pass completes, counts down in GAP.
  always_ff @(posedge clk) begin
    if (rst)                                  gap_cnt <= '0;
    else if (advance)                         gap_cnt <= GAP_W'(GAP_LOAD);
    else if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_W'(1);
  end

  // Outputs decoded from the state register only.
  always_comb begin
    dog_start = (state == S_LAUNCH);
    job_done  = (state == S_FIN);
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_dog_pass_sched.sv
// Testbench for dog_pass_sched. A timeline model predicts, per cycle, when
// launches and job completions occur from scheduled cycle numbers (launch
// cycle, done cycle + gap, launch + timeout) and every output is compared.
module tb_dog_pass_sched;

  localparam int NUM_PASS = 8;
  localparam int GAP      = 2;
  localparam int TIMEOUT  = 64;
  localparam int CNT_W    = 18;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [3:0] cfg_npass;
  logic       abort;
  logic       dog_done;
  logic       dog_start;
  logic [2:0] pass_idx;
  logic       busy;
  logic       job_done;
  logic       err_tmo;

  always #5 clk = ~clk;

  dog_pass_sched #(
    .NUM_PASS(NUM_PASS),
    .GAP(GAP),
    .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_start(cfg_start),
    .cfg_npass(cfg_npass),
    .abort(abort),
    .dog_done(dog_done),
    .dog_start(dog_start),
    .pass_idx(pass_idx),
    .busy(busy),
    .job_done(job_done),
    .err_tmo(err_tmo)
  );

  int n = 0;
  int checks = 0;
  int passed = 0;

  // Timeline model state.
  bit m_active;
  int m_npass;
  int m_pidx;
  bit m_err;
  int m_launch_at = -1;
  int m_fin_at    = -1;
  int m_launch_l  = -1;
  bit m_open;

  function automatic bit m_in_run();
    return m_active && m_open && (n > m_launch_l);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, n, obs, exp);
  endtask

  task automatic check_outputs();
    bit exp_start;
    exp_start = (m_launch_at == n);
    if (exp_start) begin
      m_launch_l = n;
      m_open     = 1'b1;
    end
    check("dog_start", {31'd0, dog_start}, {31'd0, exp_start});
    check("job_done", {31'd0, job_done}, {31'd0, (m_fin_at == n)});
    check("busy", {31'd0, busy}, {31'd0, m_active});
    check("pass_idx", {29'd0, pass_idx}, m_pidx);
    check("err_tmo", {31'd0, err_tmo}, {31'd0, m_err});
  endtask

  // Advance the model by the inputs applied in cycle n.
  task automatic m_update(input bit s, input int np, input bit d, input bit a, input bit r);
    if (r) begin
      m_active = 0; m_npass = 0; m_pidx = 0; m_err = 0;
      m_launch_at = -1; m_fin_at = -1; m_open = 0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1;
        m_npass  = (np > NUM_PASS) ? NUM_PASS : np;
        m_pidx   = 0;
        m_err    = 0;
        if (m_npass == 0) m_fin_at = n + 1;
        else              m_launch_at = n + 1;
      end
    end else if (a) begin
      m_active = 0; m_pidx = 0; m_launch_at = -1; m_fin_at = -1; m_open = 0;
    end else if (m_fin_at == n) begin
      m_active = 0;
    end else if (m_in_run()) begin
      if (d) begin
        m_open = 0;
        if (m_pidx == m_npass - 1) m_fin_at = n + 1;
        else begin
          m_pidx++;
          m_launch_at = n + 1 + GAP;
        end
      end else if (n - m_launch_l == TIMEOUT) begin
        m_err    = 1;
        m_open   = 0;
        m_fin_at = n + 1;
      end
    end
  endtask

  task automatic step(input bit s, input int np, input bit d, input bit a, input bit r);
    cfg_start = s;
    cfg_npass = 4'(np);
    dog_done  = d;
    abort     = a;
    rst       = r;
    m_update(s, np, d, a, r);
    @(posedge clk);
    #1;
    n++;
    check_outputs();
  endtask

  // Drive the pipeline side of a job according to a behaviour mode until
  // busy falls or the cycle budget runs out.
  //  0: done 10 cycles after launch     1: never done
  //  2: done exactly on watchdog expiry 3: abort in the gap after pass 0
  //  4: abort together with done of pass 1
  //  5: done 4 after launch, stray cfg_start/done outside RUN
  task automatic drive(input int mode, input int maxcyc, input bit expect_end);
    int i;
    bit s, d, a;
    int np;
    for (i = 0; i < maxcyc; i++) begin
      if (!busy && i > 0) break;
      s = 0; d = 0; a = 0; np = 0;
      case (mode)
        0: d = m_in_run() && (n == m_launch_l + 10);
        1: d = 0;
        2: d = m_in_run() && (n == m_launch_l + TIMEOUT);
        3: begin
          d = m_in_run() && (n == m_launch_l + 5);
          a = m_active && !m_open && (m_pidx == 1) && (m_launch_at > n);
        end
        4: begin
          d = m_in_run() && (n == m_launch_l + 5);
          a = d && (m_pidx == 1);
        end
        default: begin
          d = m_in_run() ? (n == m_launch_l + 4) : ($urandom_range(0, 1) == 1);
          s = !m_in_run() && ($urandom_range(0, 2) == 0);
          np = $urandom_range(0, 15);
        end
      endcase
      step(s, np, d, a, 0);
    end
    if (expect_end) check("job_end_bound", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    cfg_start = 0; cfg_npass = 0; dog_done = 0; abort = 0; rst = 1;
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Three passes, done 10 cycles after each launch.
    step(1, 3, 0, 0, 0);
    drive(0, 200, 1);
    step(0, 0, 0, 0, 0);

    // Zero passes, then a clamped request.
    step(1, 0, 0, 0, 0);
    drive(0, 10, 1);
    step(1, 12, 0, 0, 0);
    drive(0, 300, 1);

    // Watchdog expiry, and done landing on the expiry cycle.
    step(1, 4, 0, 0, 0);
    drive(1, 200, 1);
    step(1, 2, 0, 0, 0);
    drive(2, 300, 1);

    // Abort in the gap, and abort together with done.
    step(1, 3, 0, 0, 0);
    drive(3, 200, 1);
    step(0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    drive(4, 200, 1);

    // Stray requests and done pulses, then a normal job.
    step(1, 5, 0, 0, 0);
    drive(5, 300, 1);
    repeat (4) step(0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    drive(0, 200, 1);

    // Reset in the middle of a pass, then a single-pass job.
    step(1, 5, 0, 0, 0);
    drive(0, 16, 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    drive(0, 50, 1);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      bit quiet;
      quiet = ((k / 500) % 3) == 2;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 15),
           !quiet && ($urandom_range(0, 5) == 0),
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 999) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
